recir_idle_lanes: RTL and testbench
===================================

// Module: recir_idle_lanes
// PURPOSE
//  Parametrised successor of the 4x8-bit idle recirculator in the PCIe PHY receive path.
//  Sits between the serial-parallel converter and the byte-striping mux. Routes LANES words
//  either to the mux path (link active) or back to the tester path (recirculation).
//  Routing is gated by a debounced link-active state machine, and filters IDLE symbols per lane.
// PARAMETERS
//  LANES     4      number of lanes, >=1
//  DATA_W    8      bits per lane word
//  SYNC_CNT  4      consecutive active_in samples needed before forwarding, >=1
//  IDLE_SYM  8'hBC  IDLE symbol (K28.5 payload), width DATA_W
// PORTS
//  clk1f       in   1              single clock; all logic on rising edge
//  reset       in   1              synchronous, active-high
//  active_in   in   1              link-active flag from serial-parallel (ex "valido")
//  in_data     in   LANES*DATA_W   lane k at [k*DATA_W +: DATA_W]
//  valid_in    in   LANES          per-lane valid
//  out_m_data  out  LANES*DATA_W   mux-path data
//  valid_outm  out  LANES          mux-path valid
//  out_t_data  out  LANES*DATA_W   tester/recirculation data
//  valid_outt  out  LANES          tester-path valid
//  state_o     out  2              00 RECIR, 01 ARM, 10 FORWARD (11 unused)
// BEHAVIOUR
//  - Reset (sync, overrides everything): state=RECIR, cnt=0, all data/valid outputs 0.
//  - All outputs registered. Latency 1 cycle: at edge t+1 the outputs show inputs sampled
//    at edge t, routed by state value held during cycle t (pre-update).
//  - FSM with counter cnt (width $clog2(SYNC_CNT+1)):
//    RECIR:   active_in=1 -> cnt=1; go FORWARD if SYNC_CNT==1, else ARM. active_in=0 -> stay.
//    ARM:     active_in=0 -> RECIR, cnt=0. active_in=1 -> cnt++; go FORWARD when cnt+1==SYNC_CNT.
//    FORWARD: active_in=0 -> RECIR, cnt=0, effective on the next cycle's routing. Else stay.
//  - Routing per lane k, given valid_in[k]=1:
//    state RECIR/ARM -> tester path.
//    state FORWARD, data!=IDLE_SYM -> mux path.
//    state FORWARD, data==IDLE_SYM -> tester path (idle recirculated, never reaches mux).
//  - Each word goes to exactly one path. The unselected path gets valid 0 and data 0 on that lane.
//  - valid_in[k]=0: both paths valid 0, data 0 for lane k.
//  - Lanes are independent. A mixed cycle in FORWARD (some lanes IDLE) splits across paths.
//  - No backpressure, no buffering: throughput 1 word/lane/cycle, no words dropped except
//    during reset.
//  - active_in toggling in ARM restarts the debounce from RECIR. Reset mid-FORWARD flushes
//    outputs to 0 on the next edge.
// CONFIGURATION
//  RECIR_IDLE_STATS_EN defined: adds ports
//    cnt_m  out 16  count of lane-words sent on the mux path
//    cnt_t  out 16  count of lane-words sent on the tester path
//  - Increment by the popcount of valid lanes routed per cycle.
//  - Saturate at 16'hFFFF; cleared by reset.
//  Not defined: ports and counters are absent; routing behaviour is identical.
// TESTING
//  1 reset=1 for 2 cycles with in_data=32'hFFFFFFFF, valid_in=4'hF
//    -> all outputs 0, state_o=00.
//  2 active_in=0, in_data=32'h11223344, valid_in=4'hF
//    -> next cycle out_t_data=32'h11223344, valid_outt=F, valid_outm=0.
//  3 active_in=1 held: state_o goes 01,01,01,10 (SYNC_CNT=4)
//    -> first mux-path data appears the cycle after state_o=10.
//  4 FORWARD, in_data=32'hBC55BC66, valid_in=4'hF
//    -> out_m_data=32'h00550066, valid_outm=4'b0101
//    -> out_t_data=32'hBC00BC00, valid_outt=4'b1010.
//  5 In ARM with cnt=2, drop active_in for 1 cycle -> state_o=00.
//    Re-assert -> FORWARD only after 4 further consecutive active cycles.
//  6 RECIR_IDLE_STATS_EN: 70000 fully-valid forwarded cycles -> cnt_m=16'hFFFF (saturated);
//    reset -> cnt_m=0, cnt_t=0.

Source files
------------

// File: rtl/recir_idle_lanes.sv
// recir_idle_lanes: per-lane router between the mux path and the tester
// (recirculation) path, gated by a debounced link-active FSM. In FORWARD,
// IDLE symbols are still recirculated and never reach the mux path.
// Optional feature macro: RECIR_IDLE_STATS_EN (adds saturating lane-word counters).
module recir_idle_lanes #(
  parameter int unsigned       LANES    = 4,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       SYNC_CNT = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM = 8'hBC
) (
  input  logic                    clk1f,
  input  logic                    reset,
  input  logic                    active_in,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        valid_in,
  output logic [LANES*DATA_W-1:0] out_m_data,
  output logic [LANES-1:0]        valid_outm,
  output logic [LANES*DATA_W-1:0] out_t_data,
  output logic [LANES-1:0]        valid_outt,
  output logic [1:0]              state_o
`ifdef RECIR_IDLE_STATS_EN
  ,
  output logic [15:0]             cnt_m,
  output logic [15:0]             cnt_t
`endif
);

  localparam int unsigned CW = $clog2(SYNC_CNT + 1);

  localparam logic [1:0] ST_RECIR   = 2'b00;
  localparam logic [1:0] ST_ARM     = 2'b01;
  localparam logic [1:0] ST_FORWARD = 2'b10;

  logic [1:0]              state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [LANES*DATA_W-1:0] m_data_nx, t_data_nx;
  logic [LANES-1:0]        m_valid_nx, t_valid_nx;

  // Debounce FSM: count consecutive active_in samples before forwarding.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_RECIR: begin
        if (active_in) begin
          cnt_nx   = CW'(1);
          state_nx = (SYNC_CNT == 1) ? ST_FORWARD : ST_ARM;
        end
      end
      ST_ARM: begin
        if (!active_in) begin
          state_nx = ST_RECIR;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
          if (32'(cnt) + 32'd1 == SYNC_CNT) state_nx = ST_FORWARD;
        end
      end
      ST_FORWARD: begin
        if (!active_in) begin
          state_nx = ST_RECIR;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_RECIR;
        cnt_nx   = '0;
      end
    endcase
  end

  // Per-lane routing decision using the state held during this cycle.
  always_comb begin
    m_data_nx  = '0;
    t_data_nx  = '0;
    m_valid_nx = '0;
    t_valid_nx = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (valid_in[k]) begin
        if (state == ST_FORWARD && in_data[k*DATA_W +: DATA_W] != IDLE_SYM) begin
          m_data_nx[k*DATA_W +: DATA_W] = in_data[k*DATA_W +: DATA_W];
          m_valid_nx[k]                 = 1'b1;
        end else begin
          t_data_nx[k*DATA_W +: DATA_W] = in_data[k*DATA_W +: DATA_W];
          t_valid_nx[k]                 = 1'b1;
        end
      end
    end
  end

  // State, counter and registered outputs; sync reset flushes everything.
  always_ff @(posedge clk1f) begin
    if (reset) begin
      state      <= ST_RECIR;
      cnt        <= '0;
      out_m_data <= '0;
      valid_outm <= '0;
      out_t_data <= '0;
      valid_outt <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      out_m_data <= m_data_nx;
      valid_outm <= m_valid_nx;
      out_t_data <= t_data_nx;
      valid_outt <= t_valid_nx;
    end
  end

  assign state_o = state;

`ifdef RECIR_IDLE_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [LANES-1:0] v);
    logic [16:0] s;
    s = {1'b0, c};
    for (int unsigned k = 0; k < LANES; k++) s = s + {16'd0, v[k]};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Saturating lane-word counters per path, advanced by this cycle's routed words.
  always_ff @(posedge clk1f) begin
    if (reset) begin
      cnt_m <= '0;
      cnt_t <= '0;
    end else begin
      cnt_m <= sat_add(cnt_m, m_valid_nx);
      cnt_t <= sat_add(cnt_t, t_valid_nx);
    end
  end
`endif

endmodule

// File: tb/tb_recir_idle_lanes.sv
// Bench for recir_idle_lanes: behavioural model (run length of active_in)
// checked on every negedge, plus literal checks of the documented scenarios.
module tb_recir_idle_lanes;
  localparam int unsigned LANES    = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SYNC_CNT = 4;
  localparam logic [7:0]  IDLE     = 8'hBC;

  logic        clk1f = 1'b0;
  logic        reset;
  logic        active_in;
  logic [31:0] in_data;
  logic [3:0]  valid_in;
  logic [31:0] out_m_data, out_t_data;
  logic [3:0]  valid_outm, valid_outt;
  logic [1:0]  state_o;
`ifdef RECIR_IDLE_STATS_EN
  logic [15:0] cnt_m, cnt_t;
`endif

  recir_idle_lanes #(.LANES(LANES), .DATA_W(DATA_W), .SYNC_CNT(SYNC_CNT), .IDLE_SYM(IDLE)) dut (
    .clk1f(clk1f), .reset(reset), .active_in(active_in), .in_data(in_data),
    .valid_in(valid_in), .out_m_data(out_m_data), .valid_outm(valid_outm),
    .out_t_data(out_t_data), .valid_outt(valid_outt), .state_o(state_o)
`ifdef RECIR_IDLE_STATS_EN
    , .cnt_m(cnt_m), .cnt_t(cnt_t)
`endif
  );

  always #5 clk1f = ~clk1f;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: link state is just the length of the current active_in run.
  int          run = 0;
  logic [31:0] e_m, e_t;
  logic [3:0]  e_vm, e_vt;
  logic [1:0]  e_st = 2'b00;
  int          s_m = 0, s_t = 0;

  always @(posedge clk1f) begin
    if (reset) begin
      run = 0; e_m = '0; e_t = '0; e_vm = '0; e_vt = '0; s_m = 0; s_t = 0;
    end else begin
      e_m = '0; e_t = '0; e_vm = '0; e_vt = '0;
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = in_data[k*8 +: 8];
        if (valid_in[k]) begin
          if (run >= SYNC_CNT && b != IDLE) begin
            e_m[k*8 +: 8] = b; e_vm[k] = 1'b1; s_m++;
          end else begin
            e_t[k*8 +: 8] = b; e_vt[k] = 1'b1; s_t++;
          end
        end
      end
      if (s_m > 65535) s_m = 65535;
      if (s_t > 65535) s_t = 65535;
      run = active_in ? ((run < SYNC_CNT) ? run + 1 : run) : 0;
    end
    e_st = (run == 0) ? 2'b00 : (run >= SYNC_CNT) ? 2'b10 : 2'b01;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk1f) begin
    if (chk_en) begin
      chk("m_data", out_m_data, e_m);
      chk("vm", {28'd0, valid_outm}, {28'd0, e_vm});
      chk("t_data", out_t_data, e_t);
      chk("vt", {28'd0, valid_outt}, {28'd0, e_vt});
      chk("state", {30'd0, state_o}, {30'd0, e_st});
`ifdef RECIR_IDLE_STATS_EN
      chk("cnt_m", {16'd0, cnt_m}, s_m[31:0]);
      chk("cnt_t", {16'd0, cnt_t}, s_t[31:0]);
`endif
    end
  end

  // Apply inputs now, then return 2 time units after the capturing edge.
  task automatic cyc(input logic r, input logic a, input logic [31:0] d, input logic [3:0] v);
    reset = r; active_in = a; in_data = d; valid_in = v;
    @(posedge clk1f);
    #2;
  endtask

  initial begin
    #1;
    // 1: reset with all-ones inputs
    cyc(1, 1, 32'hFFFFFFFF, 4'hF);
    cyc(1, 1, 32'hFFFFFFFF, 4'hF);
    chk("rst_m", out_m_data, 32'h0);
    chk("rst_t", out_t_data, 32'h0);
    chk("rst_v", {24'd0, valid_outm, valid_outt}, 32'h0);
    chk("rst_st", {30'd0, state_o}, 32'h0);
    chk_en = 1'b1;

    // 2: recirculation
    cyc(0, 0, 32'h11223344, 4'hF);
    chk("recir_t", out_t_data, 32'h11223344);
    chk("recir_vt", {28'd0, valid_outt}, 32'hF);
    chk("recir_vm", {28'd0, valid_outm}, 32'h0);

    // 3: debounce 01,01,01,10 then first mux data
    cyc(0, 1, 32'hA1A2A3A4, 4'hF); chk("arm1", {30'd0, state_o}, 32'h1);
    cyc(0, 1, 32'hA1A2A3A4, 4'hF); chk("arm2", {30'd0, state_o}, 32'h1);
    cyc(0, 1, 32'hA1A2A3A4, 4'hF); chk("arm3", {30'd0, state_o}, 32'h1);
    cyc(0, 1, 32'hA1A2A3A4, 4'hF); chk("fwd", {30'd0, state_o}, 32'h2);
    chk("arm_last_t", out_t_data, 32'hA1A2A3A4);
    cyc(0, 1, 32'h12345678, 4'hF);
    chk("first_m", out_m_data, 32'h12345678);

    // 4: mixed idle split
    cyc(0, 1, 32'hBC55BC66, 4'hF);
    chk("mix_m", out_m_data, 32'h00550066);
    chk("mix_vm", {28'd0, valid_outm}, 32'h5);
    chk("mix_t", out_t_data, 32'hBC00BC00);
    chk("mix_vt", {28'd0, valid_outt}, 32'hA);

    // 5: drop in ARM with cnt=2 restarts the debounce
    cyc(0, 0, 32'h0, 4'h0);
    cyc(0, 1, 32'h0, 4'h0);
    cyc(0, 1, 32'h0, 4'h0);
    cyc(0, 0, 32'h0, 4'h0); chk("drop", {30'd0, state_o}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'h0, 4'h0); chk("rearm", {30'd0, state_o}, 32'h1);
    end
    cyc(0, 1, 32'h0, 4'h0); chk("refwd", {30'd0, state_o}, 32'h2);

    // Reset mid-FORWARD flushes outputs
    cyc(0, 1, 32'h01020304, 4'hF);
    cyc(1, 1, 32'h01020304, 4'hF);
    chk("flush_m", out_m_data, 32'h0);
    chk("flush_vm", {28'd0, valid_outm}, 32'h0);
    chk("flush_st", {30'd0, state_o}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      for (int k = 0; k < 4; k++)
        d[k*8 +: 8] = ($urandom_range(0, 9) < 3) ? IDLE : 8'($urandom);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), d, 4'($urandom));
    end

`ifdef RECIR_IDLE_STATS_EN
    // 6: counter saturation and clear
    cyc(1, 0, 32'h0, 4'h0);
    for (int i = 0; i < 70000; i++) cyc(0, 1, 32'h01020304, 4'hF);
    chk("sat_m", {16'd0, cnt_m}, 32'hFFFF);
    cyc(1, 0, 32'h0, 4'h0);
    chk("clr_m", {16'd0, cnt_m}, 32'h0);
    chk("clr_t", {16'd0, cnt_t}, 32'h0);
`endif

    cyc(0, 0, 32'h0, 4'h0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
